// File: rtl/decrypt_seq_pkg.sv
// Shared constants for the decrypter sequencer: frame geometry, timeout default and FSM encodings.
package decrypt_seq_pkg;

    localparam int unsigned DSEQ_IN_BYTES    = 1984;
    localparam int unsigned DSEQ_ADDR_W      = 11;
    localparam int unsigned DSEQ_OUT_WORDS   = 8;
    localparam int unsigned DSEQ_OADDR_W     = 3;
    localparam int unsigned DSEQ_TIMEOUT_CYC = 1048576;

    localparam int unsigned ST_W = 3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_DRST  = 3'd2;
    localparam logic [2:0] ST_START = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_RADDR = 3'd5;
    localparam logic [2:0] ST_RDATA = 3'd6;
    localparam logic [2:0] ST_SEND  = 3'd7;

endpackage

// File: rtl/dseq_watchdog.sv
// Decrypter run-time watchdog; only present when DSEQ_TIMEOUT_EN is defined.
// expire_o rises in the TIMEOUT_CYC-th counted cycle after load_i.
`ifdef DSEQ_TIMEOUT_EN
module dseq_watchdog
    import decrypt_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DSEQ_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic count_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt_q;
    logic             expire_q;

    // Flag is registered one count early so the FSM can act in the final counted cycle.
    always_ff @(posedge clk) begin
        if (rst || load_i) begin
            cnt_q    <= '0;
            expire_q <= 1'b0;
        end else if (count_i && !expire_q) begin
            cnt_q    <= cnt_q + CNT_W'(1);
            expire_q <= (cnt_q == CNT_W'(TIMEOUT_CYC - 2));
        end
    end

    assign expire_o = expire_q;

endmodule
`endif

// File: rtl/decrypt_sequencer.sv
// Loads one ciphertext+key frame into the decrypter, runs it and streams the result words out.
// Optional decrypter timeout watchdog enabled by defining DSEQ_TIMEOUT_EN.
module decrypt_sequencer
    import decrypt_seq_pkg::*;
#(
    parameter int unsigned IN_BYTES  = DSEQ_IN_BYTES,
    parameter int unsigned ADDR_W    = DSEQ_ADDR_W,
    parameter int unsigned OUT_WORDS = DSEQ_OUT_WORDS,
    parameter int unsigned OADDR_W   = DSEQ_OADDR_W
`ifdef DSEQ_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = DSEQ_TIMEOUT_CYC
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [31:0]        m_data,
    output logic               m_valid,
    output logic               m_last,
    input  logic               m_ready,
    output logic               busy,
    output logic               err,
    output logic               dec_rst,
    output logic               dec_start,
    input  logic               dec_done,
    output logic [7:0]         dec_dia,
    output logic               dec_wea,
    output logic [ADDR_W-1:0]  dec_addra,
    output logic [OADDR_W-1:0] dec_oaddr,
    input  logic [31:0]        dec_odo
);

    logic [ST_W-1:0]    state_q,     state_d;
    logic [ADDR_W-1:0]  byte_cnt_q,  byte_cnt_d;
    logic               s_ready_q,   s_ready_d;
    logic               dec_wea_q,   dec_wea_d;
    logic [7:0]         dec_dia_q,   dec_dia_d;
    logic [ADDR_W-1:0]  dec_addra_q, dec_addra_d;
    logic               dec_rst_q,   dec_rst_d;
    logic               dec_start_q, dec_start_d;
    logic [OADDR_W-1:0] dec_oaddr_q, dec_oaddr_d;
    logic [31:0]        m_data_q,    m_data_d;
    logic               m_valid_q,   m_valid_d;
    logic               m_last_q,    m_last_d;
    logic               busy_q,      busy_d;
    logic               byte_acc_c;
    logic               last_byte_c;

`ifdef DSEQ_TIMEOUT_EN
    logic err_q, err_d;
    logic wd_load_c, wd_count_c, wd_expire_c;

    dseq_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .load_i   (wd_load_c),
        .count_i  (wd_count_c),
        .expire_o (wd_expire_c)
    );
`endif

    assign byte_acc_c  = s_valid & s_ready_q;
    assign last_byte_c = (byte_cnt_q == ADDR_W'(IN_BYTES - 1));

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        dec_wea_d   = 1'b0;
        dec_dia_d   = dec_dia_q;
        dec_addra_d = dec_addra_q;
        dec_rst_d   = 1'b0;
        dec_start_d = 1'b0;
        dec_oaddr_d = dec_oaddr_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
`ifdef DSEQ_TIMEOUT_EN
        err_d       = err_q;
        wd_load_c   = 1'b0;
        wd_count_c  = 1'b0;
`endif

        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (byte_acc_c) begin
                    dec_wea_d   = 1'b1;
                    dec_dia_d   = s_data;
                    dec_addra_d = byte_cnt_q;
                    if (last_byte_c) begin
                        state_d = ST_DRST;
                    end else begin
                        byte_cnt_d = byte_cnt_q + ADDR_W'(1);
                        state_d    = ST_LOAD;
                    end
                end
            end
            ST_DRST: begin
                dec_rst_d  = 1'b1;
                byte_cnt_d = '0;
                state_d    = ST_START;
            end
            ST_START: begin
                dec_start_d = 1'b1;
`ifdef DSEQ_TIMEOUT_EN
                wd_load_c   = 1'b1;
`endif
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
`ifdef DSEQ_TIMEOUT_EN
                wd_count_c = !dec_done;
`endif
                if (dec_done) begin
                    dec_oaddr_d = '0;
                    state_d     = ST_RADDR;
                end
`ifdef DSEQ_TIMEOUT_EN
                else if (wd_expire_c) begin
                    err_d     = 1'b1;
                    dec_rst_d = 1'b1;
                    state_d   = ST_IDLE;
                end
`endif
            end
            ST_RADDR: begin
                state_d = ST_RDATA;
            end
            ST_RDATA: begin
                m_data_d  = dec_odo;
                m_valid_d = 1'b1;
                m_last_d  = (dec_oaddr_q == OADDR_W'(OUT_WORDS - 1));
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    if (m_last_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        dec_oaddr_d = dec_oaddr_q + OADDR_W'(1);
                        state_d     = ST_RADDR;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        s_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            byte_cnt_q  <= '0;
            s_ready_q   <= 1'b0;
            dec_wea_q   <= 1'b0;
            dec_dia_q   <= '0;
            dec_addra_q <= '0;
            dec_rst_q   <= 1'b1;
            dec_start_q <= 1'b0;
            dec_oaddr_q <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            s_ready_q   <= s_ready_d;
            dec_wea_q   <= dec_wea_d;
            dec_dia_q   <= dec_dia_d;
            dec_addra_q <= dec_addra_d;
            dec_rst_q   <= dec_rst_d;
            dec_start_q <= dec_start_d;
            dec_oaddr_q <= dec_oaddr_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            busy_q      <= busy_d;
        end
    end

`ifdef DSEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign s_ready   = s_ready_q;
    assign dec_wea   = dec_wea_q;
    assign dec_dia   = dec_dia_q;
    assign dec_addra = dec_addra_q;
    assign dec_rst   = dec_rst_q;
    assign dec_start = dec_start_q;
    assign dec_oaddr = dec_oaddr_q;
    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign busy      = busy_q;

endmodule
